// File: rtl/trace_dispatcher.sv
// Trace dispatcher: buffers (command, address) pairs from the trace reader in a
// small FIFO, decodes them and issues one operation at a time to the L2 cache.
// Maintenance ops (clear/print) wait for op_done; illegal codes are dropped and counted.
// An entry written at one edge is popped on the next edge straight into the ISSUE
// holding registers, so a steady stream runs at one op per two cycles.
module trace_dispatcher #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CMD_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [3:0]        op_code,
  output logic [ADDR_W-1:0] op_addr,
  input  logic              op_done,
  output logic              err_pulse,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_l1,
  output logic [CNT_W-1:0]  cnt_snoop,
  output logic [CNT_W-1:0]  cnt_maint,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [CMD_W-1:0]  fifo_cmd  [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              empty, full, push, pop;

  logic [CMD_W-1:0]  head_cmd;
  logic [ADDR_W-1:0] head_addr;
  logic              head_legal;
  logic [3:0]        head_code;

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_code_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic              err_q;
  logic              accept;
  logic [CNT_W-1:0]  cnt_l1_q, cnt_snoop_q, cnt_maint_q, cnt_illegal_q;

  // Saturating increment: counters stick at all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // FIFO status, handshakes and head-entry decode.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Held low during reset; no bypass, so a full FIFO never accepts.
    in_ready   = rst_n && !full;
    push       = in_valid && in_ready;
    pop        = (state_q == ST_IDLE) && !empty;
    head_cmd   = fifo_cmd[rd_ptr_q[PTR_W-1:0]];
    head_addr  = fifo_addr[rd_ptr_q[PTR_W-1:0]];
    // Full-width compare: any nonzero upper bit makes the code illegal.
    head_legal = (head_cmd <= CMD_W'(9)) && (head_cmd != CMD_W'(7));
    head_code  = head_cmd[3:0];
    accept     = (state_q == ST_ISSUE) && op_ready;
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd[wr_ptr_q[PTR_W-1:0]]  <= in_cmd;
      fifo_addr[wr_ptr_q[PTR_W-1:0]] <= in_addr;
    end
  end

  // FIFO pointers with one extra wrap bit for full/empty detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Next-state logic for the issue FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pop && head_legal) state_d = ST_ISSUE;
      ST_ISSUE:     if (op_ready) state_d = op_code_q[3] ? ST_WAIT_DONE : ST_IDLE;
      ST_WAIT_DONE: if (op_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM state, operation holding registers and the illegal-drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_code_q <= '0;
      op_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= pop && !head_legal;
      if (pop && head_legal) begin
        op_code_q <= head_code;
        // Clear and print carry no address.
        op_addr_q <= head_code[3] ? '0 : head_addr;
      end
    end
  end

  // Statistics: L1/snoop counted on accept, maintenance on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_l1_q      <= '0;
      cnt_snoop_q   <= '0;
      cnt_maint_q   <= '0;
      cnt_illegal_q <= '0;
    end else begin
      if (pop && !head_legal) cnt_illegal_q <= sat_inc(cnt_illegal_q);
      if (accept && !op_code_q[3]) begin
        if (op_code_q < 4'd3) cnt_l1_q    <= sat_inc(cnt_l1_q);
        else                  cnt_snoop_q <= sat_inc(cnt_snoop_q);
      end
      if ((state_q == ST_WAIT_DONE) && op_done) cnt_maint_q <= sat_inc(cnt_maint_q);
    end
  end

  // Output mapping.
  always_comb begin
    op_valid    = (state_q == ST_ISSUE);
    op_code     = op_code_q;
    op_addr     = op_addr_q;
    err_pulse   = err_q;
    busy        = !empty || (state_q != ST_IDLE);
    cnt_l1      = cnt_l1_q;
    cnt_snoop   = cnt_snoop_q;
    cnt_maint   = cnt_maint_q;
    cnt_illegal = cnt_illegal_q;
  end

endmodule

// File: tb/tb_trace_dispatcher.sv
// Bench for trace_dispatcher: table of single-command vectors plus hand-written
// multi-cycle sequences. Counters are narrowed to 4 bits so saturation is reachable.
module tb_trace_dispatcher;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, op_valid, op_ready, op_done, err_pulse, busy;
  logic [31:0]   in_cmd, in_addr, op_addr;
  logic [3:0]    op_code;
  logic [CW-1:0] cnt_l1, cnt_snoop, cnt_maint, cnt_illegal;

  trace_dispatcher #(
    .ADDR_W(32), .CMD_W(32), .FIFO_DEPTH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_addr(op_addr),
    .op_done(op_done), .err_pulse(err_pulse), .busy(busy),
    .cnt_l1(cnt_l1), .cnt_snoop(cnt_snoop), .cnt_maint(cnt_maint), .cnt_illegal(cnt_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_l1 = 0, m_sn = 0, m_mt = 0, m_il = 0;
  int err_cnt = 0;
  logic [3:0] acc_log[$];

  // Record accepted ops and error pulses away from the active edge.
  always @(negedge clk) begin
    if (err_pulse) err_cnt++;
    if (op_valid && op_ready) acc_log.push_back(op_code);
  end

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [3:0]  code;
    logic [31:0] oaddr;
    int          cls;  // 0 l1, 1 snoop, 2 maint, 3 illegal
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] sat(input int v);
    return (v > 15) ? 4'hF : v[CW-1:0];
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cnt_l1"}, 64'(cnt_l1), 64'(sat(m_l1)));
    check({tag, "_cnt_snoop"}, 64'(cnt_snoop), 64'(sat(m_sn)));
    check({tag, "_cnt_maint"}, 64'(cnt_maint), 64'(sat(m_mt)));
    check({tag, "_cnt_illegal"}, 64'(cnt_illegal), 64'(sat(m_il)));
  endtask

  // Present one entry and hold it until it is taken; returns just after that edge.
  task automatic push(input logic [31:0] c, input logic [31:0] a);
    int n = 0;
    in_cmd   = c;
    in_addr  = a;
    in_valid = 1'b1;
    while (!in_ready && n < 64) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: in_ready got 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    vecs[0]  = '{32'h0000_0000, 32'h0000_0100, 4'd0, 32'h0000_0100, 0};
    vecs[1]  = '{32'h0000_0001, 32'h0000_0200, 4'd1, 32'h0000_0200, 0};
    vecs[2]  = '{32'h0000_0002, 32'hFFFF_FFFC, 4'd2, 32'hFFFF_FFFC, 0};
    vecs[3]  = '{32'h0000_0003, 32'h0000_0400, 4'd3, 32'h0000_0400, 1};
    vecs[4]  = '{32'h0000_0004, 32'h1234_5678, 4'd4, 32'h1234_5678, 1};
    vecs[5]  = '{32'h0000_0005, 32'h0000_0600, 4'd5, 32'h0000_0600, 1};
    vecs[6]  = '{32'h0000_0006, 32'h8000_0000, 4'd6, 32'h8000_0000, 1};
    vecs[7]  = '{32'h0000_0008, 32'h0000_AAAA, 4'd8, 32'h0000_0000, 2};
    vecs[8]  = '{32'h0000_0009, 32'h0000_5555, 4'd9, 32'h0000_0000, 2};
    vecs[9]  = '{32'h0000_0007, 32'h0000_0700, 4'd0, 32'h0000_0000, 3};
    vecs[10] = '{32'h0000_000A, 32'h0000_0A00, 4'd0, 32'h0000_0000, 3};
    vecs[11] = '{32'h0001_0009, 32'h0000_0B00, 4'd0, 32'h0000_0000, 3};
    vecs[12] = '{32'hFFFF_FFFF, 32'h0000_0C00, 4'd0, 32'h0000_0000, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_addr = '0; op_ready = 1'b0; op_done = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_op_valid", 64'(op_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_pulse), 64'd0);
    check("rst_op_code", 64'(op_code), 64'd0);
    check("rst_op_addr", 64'(op_addr), 64'd0);
    check_counters("rst");
    #3 rst_n = 1'b1;
    tick();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Table: one command at a time through the full handshake.
    for (int i = 0; i < 13; i++) begin
      push(vecs[i].cmd, vecs[i].addr);
      check("tbl_no_early_valid", 64'(op_valid), 64'd0);
      tick();
      if (vecs[i].cls == 3) begin
        check("tbl_err_pulse", 64'(err_pulse), 64'd1);
        check("tbl_ill_no_valid", 64'(op_valid), 64'd0);
        m_il++;
        tick();
        check("tbl_err_single", 64'(err_pulse), 64'd0);
      end else begin
        check("tbl_op_valid", 64'(op_valid), 64'd1);
        check("tbl_op_code", 64'(op_code), 64'(vecs[i].code));
        check("tbl_op_addr", 64'(op_addr), 64'(vecs[i].oaddr));
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        if (vecs[i].cls == 2) begin
          check("tbl_wait_no_valid", 64'(op_valid), 64'd0);
          check("tbl_wait_busy", 64'(busy), 64'd1);
          repeat (3) tick();
          op_done = 1'b1;
          tick();
          op_done = 1'b0;
          m_mt++;
        end else if (vecs[i].cls == 1) begin
          m_sn++;
        end else begin
          m_l1++;
        end
      end
      check("tbl_busy_clear", 64'(busy), 64'd0);
      check_counters("tbl");
    end

    // Latency: op_valid two cycles after presenting, busy drops after accept.
    op_ready = 1'b1;
    in_cmd = 32'h0; in_addr = 32'h0000_1F40; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_valid_c1", 64'(op_valid), 64'd0);
    tick();
    check("lat_valid_c2", 64'(op_valid), 64'd1);
    check("lat_code", 64'(op_code), 64'd0);
    check("lat_addr", 64'(op_addr), 64'h1F40);
    tick();
    m_l1++;
    check("lat_valid_after", 64'(op_valid), 64'd0);
    check("lat_busy_after", 64'(busy), 64'd0);
    check_counters("lat");
    op_ready = 1'b0;

    // Back-pressure: five pushes fill ISSUE plus four FIFO slots, then drain in order.
    for (int i = 1; i <= 5; i++) push(32'(i), 32'h1000 + 32'(i));
    check("bp_in_ready_full", 64'(in_ready), 64'd0);
    check("bp_head_code", 64'(op_code), 64'd1);
    acc_log.delete();
    op_ready = 1'b1;
    repeat (30) tick();
    op_ready = 1'b0;
    check("bp_count", 64'(acc_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++)
      check("bp_order", 64'(acc_log[i]), 64'(i + 1));
    m_l1 += 2; m_sn += 3;
    check_counters("bp");

    // Maintenance blocks the following command until op_done.
    op_ready = 1'b1;
    push(32'h8, 32'h0000_1234);
    push(32'h0, 32'h0000_5678);
    check("mt_valid", 64'(op_valid), 64'd1);
    check("mt_code", 64'(op_code), 64'd8);
    check("mt_addr_zero", 64'(op_addr), 64'd0);
    tick();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (op_valid) stable = 1'b0;
      tick();
    end
    check("mt_blocked", 64'(stable), 64'd1);
    check("mt_not_done_cnt", 64'(cnt_maint), 64'(sat(m_mt)));
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    m_mt++;
    tick();
    check("mt_next_valid", 64'(op_valid), 64'd1);
    check("mt_next_code", 64'(op_code), 64'd0);
    check("mt_next_addr", 64'(op_addr), 64'h5678);
    tick();
    m_l1++;
    op_ready = 1'b0;
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check_counters("mt");

    // Illegal codes back to back, then a legal one.
    err_cnt = 0;
    acc_log.delete();
    op_ready = 1'b1;
    push(32'h7, 32'h0);
    push(32'h0001_0009, 32'h0);
    push(32'h6, 32'h0000_0066);
    repeat (8) tick();
    op_ready = 1'b0;
    m_il += 2; m_sn++;
    check("ill_err_cycles", 64'(err_cnt), 64'd2);
    check("ill_issued", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() > 0) check("ill_code", 64'(acc_log[0]), 64'd6);
    check_counters("ill");

    // Long stall: outputs stay stable while op_ready is low.
    push(32'h4, 32'hDEAD_BEEF);
    tick();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!op_valid || op_code != 4'd4 || op_addr != 32'hDEAD_BEEF) stable = 1'b0;
      tick();
    end
    check("stall_stable", 64'(stable), 64'd1);
    acc_log.delete();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    repeat (3) tick();
    check("stall_single_accept", 64'(acc_log.size()), 64'd1);
    m_sn++;
    check_counters("stall");

    // Saturation: 16 more L1 ops drive cnt_l1 past all-ones.
    op_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(32'h2, 32'(i));
    repeat (12) tick();
    op_ready = 1'b0;
    m_l1 += 16;
    check("sat_cnt_l1", 64'(cnt_l1), 64'hF);
    check_counters("sat");

    // Reset mid-ISSUE with three entries queued.
    for (int i = 1; i <= 4; i++) push(32'(i), 32'h2000 + 32'(i));
    check("mid_valid_pre", 64'(op_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    m_l1 = 0; m_sn = 0; m_mt = 0; m_il = 0;
    check("mid_valid_drop", 64'(op_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd0);
    check_counters("mid");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    acc_log.delete();
    op_ready = 1'b1;
    repeat (6) tick();
    op_ready = 1'b0;
    check("post_rst_nothing", 64'(acc_log.size()), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
